// File: rtl/fetch_pc_gen.sv
// Front-end PC generator: issues sequential imem fetches under a credit limit,
// drops stale responses after a redirect and buffers {pc, instr} toward decode.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned BUF_DEPTH       = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exec_jump_valid,
  input  logic [31:0] exec_jump_pc,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr,
  input  logic        decode_ready,
  output logic        flush_out
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BW = $clog2(BUF_DEPTH + 1);

  logic          active_q;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] rq_cnt_q, rq_cnt_d;
  logic [31:0]   rq_pc_q [MAX_OUTSTANDING];
  logic [31:0]   rq_pc_d [MAX_OUTSTANDING];
  logic [BW-1:0] buf_cnt_q, buf_cnt_d;
  logic [31:0]   buf_pc_q  [BUF_DEPTH];
  logic [31:0]   buf_pc_d  [BUF_DEPTH];
  logic [31:0]   buf_ins_q [BUF_DEPTH];
  logic [31:0]   buf_ins_d [BUF_DEPTH];
  logic          flush_q, flush_d;

  logic        redirect;
  logic [31:0] target;
  logic        req_ok;
  logic        accept;
  logic        resp_ok;
  logic        resp_keep;
  logic        resp_drop;
  logic        dec_pop;
  int          rq_wr;
  int          buf_wr;

  // Credits count buffered plus in-flight entries, so every response has a slot.
  assign req_ok    = active_q
                     && (32'(out_q) < MAX_OUTSTANDING)
                     && ((32'(out_q) + 32'(buf_cnt_q)) < BUF_DEPTH);
  assign accept    = req_ok && imem_req_ready;
  assign resp_ok   = imem_resp_valid && (out_q != '0);
  assign resp_drop = resp_ok && (disc_q != '0);
  assign resp_keep = resp_ok && (disc_q == '0);
  assign dec_pop   = (buf_cnt_q != '0) && decode_ready;
  assign redirect  = trap_valid || exec_jump_valid;
  assign target    = trap_valid ? trap_pc : exec_jump_pc;

  always_comb begin
    out_d   = out_q + CW'(accept) - CW'(resp_ok);
    disc_d  = disc_q - CW'(resp_drop);
    flush_d = redirect;
    pc_d    = pc_q;
    if (redirect) begin
      pc_d   = target & 32'hFFFF_FFFC;
      disc_d = out_d;
    end else if (accept) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_comb begin
    rq_pc_d  = rq_pc_q;
    rq_cnt_d = rq_cnt_q + CW'(accept) - CW'(resp_keep);
    rq_wr    = int'(rq_cnt_q) - int'(resp_keep);
    if (resp_keep) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING) - 1; i++) rq_pc_d[i] = rq_pc_q[i+1];
    end
    if (accept) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        if (i == rq_wr) rq_pc_d[i] = pc_q;
      end
    end
    if (redirect) rq_cnt_d = '0;
  end

  always_comb begin
    buf_pc_d  = buf_pc_q;
    buf_ins_d = buf_ins_q;
    buf_cnt_d = buf_cnt_q + BW'(resp_keep) - BW'(dec_pop);
    buf_wr    = int'(buf_cnt_q) - int'(dec_pop);
    if (dec_pop) begin
      for (int i = 0; i < int'(BUF_DEPTH) - 1; i++) begin
        buf_pc_d[i]  = buf_pc_q[i+1];
        buf_ins_d[i] = buf_ins_q[i+1];
      end
    end
    if (resp_keep) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        if (i == buf_wr) begin
          buf_pc_d[i]  = rq_pc_q[0];
          buf_ins_d[i] = imem_resp_data;
        end
      end
    end
    // A redirect wipes the buffer, cancelling any same-cycle push or pop.
    if (redirect) buf_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q  <= 1'b0;
      pc_q      <= RESET_PC;
      out_q     <= '0;
      disc_q    <= '0;
      rq_cnt_q  <= '0;
      buf_cnt_q <= '0;
      flush_q   <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) rq_pc_q[i] <= '0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        buf_pc_q[i]  <= '0;
        buf_ins_q[i] <= '0;
      end
    end else begin
      active_q  <= 1'b1;
      pc_q      <= pc_d;
      out_q     <= out_d;
      disc_q    <= disc_d;
      rq_cnt_q  <= rq_cnt_d;
      buf_cnt_q <= buf_cnt_d;
      flush_q   <= flush_d;
      rq_pc_q   <= rq_pc_d;
      buf_pc_q  <= buf_pc_d;
      buf_ins_q <= buf_ins_d;
    end
  end

  assign imem_req_valid = req_ok;
  assign imem_req_addr  = pc_q;
  assign fetch_valid    = (buf_cnt_q != '0);
  assign fetch_pc       = buf_pc_q[0];
  assign fetch_instr    = buf_ins_q[0];
  assign flush_out      = flush_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scoreboard bench for fetch_pc_gen: memory model with epoch-tagged requests,
// expected {pc, instr} queued on delivered responses and checked on decode pops.
module tb_fetch_pc_gen;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        exec_jump_valid = 1'b0;
  logic [31:0] exec_jump_pc = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        decode_ready = 1'b0;
  logic        flush_out;

  fetch_pc_gen #(.RESET_PC(RESET_PC), .MAX_OUTSTANDING(2), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .exec_jump_valid(exec_jump_valid), .exec_jump_pc(exec_jump_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .decode_ready(decode_ready), .flush_out(flush_out)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int ep; } mem_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mem_t        mem_q[$];
  exp_t        exp_q[$];
  int          epoch = 0;
  logic [31:0] model_pc = RESET_PC;
  logic        mem_hold = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_pops = 0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a * 32'd7) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, observe before the edge, update the model after it.
  task automatic cyc(input logic jv, input logic [31:0] jpc, input logic tv, input logic [31:0] tpc);
    logic        redir, acc, r_live;
    logic [31:0] acc_addr, r_addr;
    int          r_ep;
    mem_t        m;
    exp_t        e;
    @(negedge clk);
    exec_jump_valid = jv; exec_jump_pc = jpc;
    trap_valid = tv; trap_pc = tpc;
    r_live = 1'b0; r_addr = '0; r_ep = 0;
    if (!mem_hold && mem_q.size() > 0) begin
      m = mem_q.pop_front();
      r_live = 1'b1; r_addr = m.addr; r_ep = m.ep;
      imem_resp_valid = 1'b1; imem_resp_data = mdata(m.addr);
    end else begin
      imem_resp_valid = 1'b0; imem_resp_data = '0;
    end
    #1;
    redir = jv || tv;
    if (!redir && fetch_valid && decode_ready) begin
      if (exp_q.size() == 0) chk("unexpected_pop", {31'd0, fetch_valid}, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("pop_pc", fetch_pc, e.pc);
        chk("pop_instr", fetch_instr, e.instr);
        n_pops++;
      end
    end
    acc = imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    if (acc) chk("req_addr", acc_addr, model_pc);
    @(posedge clk); #1;
    if (acc) begin
      mem_q.push_back('{addr: acc_addr, ep: epoch});
      model_pc = model_pc + 32'd4;
    end
    if (r_live && r_ep == epoch && !redir)
      exp_q.push_back('{pc: r_addr, instr: mdata(r_addr)});
    if (redir) begin
      exp_q.delete();
      epoch++;
      model_pc = (tv ? tpc : jpc) & 32'hFFFF_FFFC;
    end
    chk("flush_out", {31'd0, flush_out}, {31'd0, redir});
    exec_jump_valid = 1'b0; trap_valid = 1'b0;
    imem_resp_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0;
    exec_jump_valid = 1'b0; trap_valid = 1'b0;
    #1;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_flush", {31'd0, flush_out}, 32'd0);
    chk("rst_fetch_pc", fetch_pc, 32'd0);
    chk("rst_fetch_instr", fetch_instr, 32'd0);
    mem_q.delete(); exp_q.delete();
    epoch++;
    model_pc = RESET_PC;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, RESET_PC);
  endtask

  // Hold decode off until the head is valid, then compare its PC.
  task automatic wait_fetch(input string tag, input logic [31:0] exp_pc);
    int i;
    decode_ready = 1'b0;
    for (i = 0; i < 30 && !fetch_valid; i++) idle(1);
    if (!fetch_valid) chk({tag, "_timeout"}, {31'd0, fetch_valid}, 32'd1);
    else chk(tag, fetch_pc, exp_pc);
  endtask

  initial begin
    int pops0;
    #2;
    imem_req_ready = 1'b1;
    do_reset();

    decode_ready = 1'b1;
    idle(30);
    chk("stream_progress", {31'd0, n_pops >= 8}, 32'd1);

    decode_ready = 1'b0;
    idle(10);
    chk("stall_fetch_valid", {31'd0, fetch_valid}, 32'd1);
    chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    pops0 = n_pops;
    decode_ready = 1'b1;
    idle(15);
    chk("stall_release_pops", {31'd0, n_pops > pops0}, 32'd1);

    mem_hold = 1'b1;
    idle(8);
    chk("two_outstanding_block", {31'd0, imem_req_valid}, 32'd0);
    cyc(1'b1, 32'h0000_0100, 1'b0, '0);
    mem_hold = 1'b0;
    wait_fetch("jump_target", 32'h0000_0100);

    cyc(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0080);
    wait_fetch("trap_priority", 32'h0000_0080);

    cyc(1'b1, 32'h0000_0200, 1'b0, '0);
    cyc(1'b1, 32'h0000_0103, 1'b0, '0);
    wait_fetch("align_target", 32'h0000_0100);

    cyc(1'b1, 32'hFFFF_FFFC, 1'b0, '0);
    wait_fetch("wrap_last", 32'hFFFF_FFFC);
    decode_ready = 1'b1;
    idle(1);
    wait_fetch("wrap_zero", 32'h0000_0000);

    for (int i = 0; i < 300; i++) begin
      decode_ready   = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      mem_hold       = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 24) == 0) cyc(1'b1, $urandom, 1'b0, '0);
      else if ($urandom_range(0, 49) == 0) cyc(1'b0, '0, 1'b1, $urandom);
      else idle(1);
    end
    mem_hold = 1'b0; imem_req_ready = 1'b0; decode_ready = 1'b1;
    idle(12);
    chk("drain_empty", {31'd0, fetch_valid}, 32'd0);
    chk("drain_scoreboard", exp_q.size(), 32'd0);

    imem_req_ready = 1'b1;
    for (int i = 0; i < 10 && mem_q.size() == 0; i++) idle(1);
    chk("resp_pending_before_reset", {31'd0, mem_q.size() > 0}, 32'd1);
    do_reset();
    decode_ready = 1'b1;
    idle(10);
    chk("post_reset_pops", {31'd0, exp_q.size() <= 2 && n_pops > 0}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
